core_int_ctrl: RTL
==================

# core_int_ctrl

Machine-mode interrupt controller feeding the writeback stage's `int_pending`/`int_cause`/`int_tvec`/`int_ack` interface. It samples the external, software and timer interrupt lines and maintains the MIP pending bits. It applies MIE/MSTATUS.MIE masking and fixed-priority arbitration, then presents one stable, registered interrupt request to writeback. The request is held until writeback acknowledges the control-flow change, and interrupts are blocked until the CSR unit has cleared MSTATUS.MIE.

## Interface
Parameters:
- None. Widths `XL` and `CF_CAUSE_R` come from the common core header.

Ports:
- `g_clk` in 1: global clock.
- `g_resetn` in 1: reset, synchronous, active-low.
- `ext_int` in 1: external interrupt line, level, asynchronous.
- `sw_int` in 1: software interrupt line, level, `g_clk` domain.
- `timer_int` in 1: timer compare interrupt line, level, `g_clk` domain.
- `mie_meie`, `mie_msie`, `mie_mtie` in 1 each: per-source enables from the CSR unit.
- `mstatus_mie` in 1: global interrupt enable from the CSR unit.
- `mtvec_base` in XL+1: trap vector base, 4-byte aligned.
- `mtvec_mode` in 2: `0` selects direct mode, `1` selects vectored mode.
- `mip_meip`, `mip_msip`, `mip_mtip` out 1 each: registered pending bits, for CSR readback.
- `int_pending` out 1: interrupt request to writeback.
- `int_cause` out CF_CAUSE_R+1: cause code, zero-extended.
- `int_tvec` out XL+1: trap target address.
- `int_ack` in 1: writeback has taken the interrupt control-flow change.

## Operation
- **Pending bits:**
  - `ext_int` passes through a 2-flop synchronizer; the second flop is `mip_meip`.
  - `mip_msip` <= `sw_int` and `mip_mtip` <= `timer_int`, every cycle.
  - All three bits are level-sensitive and are not sticky.
- **Candidate (combinational):** `mstatus_mie && (meip&meie | msip&msie | mtip&mtie)`.
- **Priority:** MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
- **State machine:**
  - IDLE:
    - `int_pending`=0.
    - If a candidate exists, latch the winning cause and its tvec, then go to PEND.
  - PEND:
    - `int_pending`=1; `int_cause` and `int_tvec` are held stable.
    - Input or enable changes are ignored; the request is never retracted.
    - On `int_ack`, go to HOLDOFF.
  - HOLDOFF:
    - `int_pending`=0.
    - When `mstatus_mie`==0 is sampled, go to IDLE.
    - Purpose: prevents a re-take before the CSR unit's trap update of MSTATUS lands.
- **Vector computation:**
  - Direct mode, or any mode other than 1: `int_tvec` = `mtvec_base`.
  - Vectored mode: `int_tvec` = `mtvec_base + (cause << 2)`, modulo 2^XLEN (wrap-around permitted).
  - The vector is computed from `mtvec_mode`/`mtvec_base` at the latch cycle and held through PEND.
- **Boundary cases:**
  - `int_ack` in IDLE or HOLDOFF is ignored; the bench flags it as a protocol error.
  - Simultaneous candidate sources: highest priority wins; losers stay pending in MIP and are taken later via IDLE.
  - Source drops while in PEND: the request remains; writeback still takes it.
  - Reset mid-operation: return to IDLE, clear all registers.

## Timing
- **Reset values:**
  - `int_pending`=0, `int_cause`=0, `int_tvec`=0.
  - `mip_*`=0, synchronizer flops=0, state=IDLE.
- All outputs are registered; there is no combinational path from any input to any output.
- **Latency (input asserted in cycle t, enables set, state IDLE):**
  - `sw_int`/`timer_int`: `mip_*` high in t+1, `int_pending` high in t+2.
  - `ext_int`: `mip_meip` high in t+2, `int_pending` high in t+3.
- **Acknowledge:**
  - `int_ack` in cycle a: `int_pending` low in a+1.
  - If `mstatus_mie`=0 is sampled in cycle h ≥ a+1, IDLE is reached in h+1.
  - The earliest new `int_pending` is h+2.
- Throughput: at most one interrupt taken per MSTATUS.MIE 1→0 cycle.

## Configuration
- `CORE_INT_VECTORED_EN`:
  - Defined: vectored mode is supported as above.
  - Undefined: `mtvec_mode` is ignored, `int_tvec` = `mtvec_base` always, and the adder is removed.

## Test plan
- Timer interrupt, vectored mode:
  - Stimulus: `mtvec_base`=0x8000_0100, mode=1, mtie=1, mstatus_mie=1; `timer_int` high in cycle 10.
  - Response: `int_pending`=1 in cycle 12, cause=7, tvec=0x8000_011C, held until `int_ack`.
- Priority:
  - Stimulus: `ext_int`, `sw_int` and `timer_int` rise together, all enabled.
  - Response: first request cause=11, tvec=0x8000_012C.
  - After ack, the MIE clear, and MIE re-set with `ext_int` low: next request cause=3, tvec=0x8000_010C.
- Stability under input change:
  - Stimulus: drop `timer_int` and clear `mie_mtie` while in PEND.
  - Response: `int_pending`, cause and tvec are unchanged until `int_ack`.
- Holdoff:
  - Stimulus: `int_ack` in cycle 20 with `timer_int` still high; `mstatus_mie` held 1 until cycle 25, 0 in cycle 25, 1 in cycle 27.
  - Response: `int_pending`=0 in cycles 21–27, then 1 in cycle 28.
- Reset and masking:
  - `g_resetn`=0 during PEND: all outputs 0 next cycle, and no request afterwards without a new candidate.
  - `mstatus_mie`=0 with sources active: `int_pending` never asserts, while `mip_*` still track the inputs.
- Macro off (`CORE_INT_VECTORED_EN` undefined):
  - Stimulus: mode=1, cause 11.
  - Response: tvec=0x8000_0100.

Source files
------------

// File: rtl/core_int_ctrl.sv
// Machine-mode interrupt controller: MIP sampling, MIE masking, fixed-priority arbitration, held request to writeback.
// Optional vectored-mode target computation is enabled by defining CORE_INT_VECTORED_EN.

`ifndef XL
`define XL 31
`endif
`ifndef CF_CAUSE_R
`define CF_CAUSE_R 5
`endif

module core_int_ctrl (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   ext_int,
    input  logic                   sw_int,
    input  logic                   timer_int,
    input  logic                   mie_meie,
    input  logic                   mie_msie,
    input  logic                   mie_mtie,
    input  logic                   mstatus_mie,
    input  logic [`XL:0]           mtvec_base,
    input  logic [1:0]             mtvec_mode,
    output logic                   mip_meip,
    output logic                   mip_msip,
    output logic                   mip_mtip,
    output logic                   int_pending,
    output logic [`CF_CAUSE_R:0]   int_cause,
    output logic [`XL:0]           int_tvec,
    input  logic                   int_ack
);

    localparam int CW = `CF_CAUSE_R + 1;
    localparam int AW = `XL + 1;
    localparam logic [CW-1:0] CAUSE_MEI = CW'(32'd11);
    localparam logic [CW-1:0] CAUSE_MSI = CW'(32'd3);
    localparam logic [CW-1:0] CAUSE_MTI = CW'(32'd7);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            ext_meta_r;
    logic            meip_r;
    logic            msip_r;
    logic            mtip_r;
    logic            pending_r;
    logic [CW-1:0]   cause_r;
    logic [AW-1:0]   tvec_r;
    logic            cand_s;
    logic [CW-1:0]   win_cause_s;
    logic [AW-1:0]   win_tvec_s;

    // Global enable gates every source; MEI beats MSI beats MTI.
    always_comb begin
        cand_s      = 1'b0;
        win_cause_s = '0;
        if (mstatus_mie && meip_r && mie_meie) begin
            cand_s      = 1'b1;
            win_cause_s = CAUSE_MEI;
        end else if (mstatus_mie && msip_r && mie_msie) begin
            cand_s      = 1'b1;
            win_cause_s = CAUSE_MSI;
        end else if (mstatus_mie && mtip_r && mie_mtie) begin
            cand_s      = 1'b1;
            win_cause_s = CAUSE_MTI;
        end else begin
            cand_s      = 1'b0;
            win_cause_s = '0;
        end
    end

`ifdef CORE_INT_VECTORED_EN
    // Vectored target wraps modulo 2^XLEN; any mode other than 1 behaves as direct.
    always_comb begin
        win_tvec_s = mtvec_base;
        if (mtvec_mode == 2'd1) begin
            win_tvec_s = mtvec_base + ({{(AW-CW){1'b0}}, win_cause_s} << 2);
        end else begin
            win_tvec_s = mtvec_base;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = ^mtvec_mode;

    // Without vectoring the target is always the base.
    always_comb begin
        win_tvec_s = mtvec_base;
    end
`endif

    // Next-state logic: HOLDOFF waits for the CSR unit to clear MSTATUS.MIE before rearming.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_s) state_nxt_s = ST_PEND;
                else        state_nxt_s = ST_IDLE;
            end
            ST_PEND: begin
                if (int_ack) state_nxt_s = ST_HOLDOFF;
                else         state_nxt_s = ST_PEND;
            end
            ST_HOLDOFF: begin
                if (!mstatus_mie) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_HOLDOFF;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pending bits and the latched request; pending is registered from the next state.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_r    <= ST_IDLE;
            ext_meta_r <= 1'b0;
            meip_r     <= 1'b0;
            msip_r     <= 1'b0;
            mtip_r     <= 1'b0;
            pending_r  <= 1'b0;
            cause_r    <= '0;
            tvec_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            ext_meta_r <= ext_int;
            meip_r     <= ext_meta_r;
            msip_r     <= sw_int;
            mtip_r     <= timer_int;
            pending_r  <= (state_nxt_s == ST_PEND);
            if ((state_r == ST_IDLE) && cand_s) begin
                cause_r <= win_cause_s;
                tvec_r  <= win_tvec_s;
            end
        end
    end

    assign mip_meip    = meip_r;
    assign mip_msip    = msip_r;
    assign mip_mtip    = mtip_r;
    assign int_pending = pending_r;
    assign int_cause   = cause_r;
    assign int_tvec    = tvec_r;

endmodule
